// File: rtl/frog_river_pkg.sv
// Shared types, default parameters and helpers for the frog river controller.
// Optional dive-fish behaviour is enabled by defining FROG_DIVE_FISH_EN.
package frog_river_pkg;

    typedef enum logic [1:0] {ALIVE, DYING, RESPAWN, OVER} frog_state_e;

    typedef enum logic [2:0] {NONE, FISH3, LOG, FISH2, BIGLOG} carrier_e;

    localparam int unsigned DEF_LOG_STEP      = 1;
    localparam int unsigned DEF_BIGLOG_STEP   = 2;
    localparam int unsigned DEF_FISH3_STEP    = 1;
    localparam int unsigned DEF_FISH2_STEP    = 2;
    localparam logic        DEF_FISH_LEFT     = 1'b1;
    localparam int unsigned DEF_WATER_CONFIRM = 2;
    localparam int unsigned DEF_DIE_FRAMES    = 32;
    localparam int unsigned DEF_LIVES_INIT    = 3;
    localparam int unsigned DEF_X_MIN         = 0;
    localparam int unsigned DEF_X_MAX         = 624;

    localparam logic [6:0]  DIVE_THRESHOLD    = 7'd96;
    localparam logic [2:0]  WATER_CNT_MAX     = 3'd7;

    function automatic logic isFish(input carrier_e c);
        return (c == FISH3) || (c == FISH2);
    endfunction

endpackage

// File: rtl/frog_river_ctrl_death_anim.sv
// Death animation counter: runs 0..DIE_FRAMES-1 after a start pulse, flags the terminal frame.
module frog_death_anim
    import frog_river_pkg::*;
#(
    parameter int unsigned DIE_FRAMES = DEF_DIE_FRAMES,
    localparam int unsigned CntW = $clog2(DIE_FRAMES)
)(
    input  logic            frame_clk,
    input  logic            Reset,
    input  logic            start,
    output logic [CntW-1:0] death_cnt,
    output logic [1:0]      death_frame,
    output logic            done
);

    logic active;

    // done is combinational on registered state so the owner can leave DYING on this edge
    assign done        = active && (death_cnt == CntW'(DIE_FRAMES - 1));
    assign death_frame = death_cnt[CntW-1 -: 2];

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            active    <= 1'b0;
            death_cnt <= '0;
        end else if (start) begin
            active    <= 1'b1;
            death_cnt <= '0;
        end else if (done) begin
            active    <= 1'b0;
            death_cnt <= '0;
        end else if (active) begin
            death_cnt <= death_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/frog_river_ctrl.sv
// River-lane controller: carrier drift, water debounce, death animation, lives and game over.
// Define FROG_DIVE_FISH_EN to add the diving three-fish timer and the fish3_submerged output.
module frog_river_ctrl
    import frog_river_pkg::*;
#(
    parameter int unsigned LOG_STEP      = DEF_LOG_STEP,
    parameter int unsigned BIGLOG_STEP   = DEF_BIGLOG_STEP,
    parameter int unsigned FISH3_STEP    = DEF_FISH3_STEP,
    parameter int unsigned FISH2_STEP    = DEF_FISH2_STEP,
    parameter logic        FISH_LEFT     = DEF_FISH_LEFT,
    parameter int unsigned WATER_CONFIRM = DEF_WATER_CONFIRM,
    parameter int unsigned DIE_FRAMES    = DEF_DIE_FRAMES,
    parameter int unsigned LIVES_INIT    = DEF_LIVES_INIT,
    parameter int unsigned X_MIN         = DEF_X_MIN,
    parameter int unsigned X_MAX         = DEF_X_MAX
)(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       onfish3,
    input  logic       onlog,
    input  logic       onfish2,
    input  logic       onbiglog,
    input  logic       water,
    input  logic       hop_active,
    input  logic [9:0] frogX,
    output logic       drift_en,
    output logic       drift_left,
    output logic [2:0] drift_step,
    output logic       dying,
    output logic [1:0] death_frame,
    output logic       respawn,
    output logic [1:0] lives,
`ifdef FROG_DIVE_FISH_EN
    output logic       fish3_submerged,
`endif
    output logic       game_over
);

    localparam int unsigned CntW = $clog2(DIE_FRAMES);
    localparam logic [9:0] XMin = X_MIN[9:0];
    localparam logic [9:0] XMax = X_MAX[9:0];

    frog_state_e     state;
    carrier_e        carrier;
    logic [2:0]      waterCnt;
    logic [2:0]      cntInc;
    logic [2:0]      stepNext;
    logic            enNext;
    logic            leftNext;
    logic            fish3Wet;
    logic            waterHit;
    logic            waterDeath;
    logic            edgeDeath;
    logic            dieNow;
    logic            animStart;
    logic            animDone;
    logic [CntW-1:0] unusedDeathCnt;

`ifdef FROG_DIVE_FISH_EN
    logic [6:0] diveTimer;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) diveTimer <= '0;
        else       diveTimer <= diveTimer + 7'd1;
    end

    assign fish3_submerged = (diveTimer >= DIVE_THRESHOLD);
    assign fish3Wet        = onfish3 && fish3_submerged;
`else
    assign fish3Wet = 1'b0;
`endif

    assign waterHit = water || fish3Wet;

    always_comb begin
        carrier = NONE;
        if (onbiglog)                  carrier = BIGLOG;
        else if (onlog)                carrier = LOG;
        else if (onfish2)              carrier = FISH2;
        else if (onfish3 && !fish3Wet) carrier = FISH3;
    end

    always_comb begin
        stepNext = '0;
        case (carrier)
            BIGLOG:  stepNext = 3'(BIGLOG_STEP);
            LOG:     stepNext = 3'(LOG_STEP);
            FISH2:   stepNext = 3'(FISH2_STEP);
            FISH3:   stepNext = 3'(FISH3_STEP);
            default: stepNext = '0;
        endcase
    end

    assign enNext   = (carrier != NONE);
    assign leftNext = enNext && (isFish(carrier) ? FISH_LEFT : !FISH_LEFT);

    // Mid-hop water contact holds the run rather than clearing it
    always_comb begin
        cntInc = '0;
        if (waterHit && !hop_active)
            cntInc = (waterCnt == WATER_CNT_MAX) ? WATER_CNT_MAX : waterCnt + 3'd1;
        else if (waterHit)
            cntInc = waterCnt;
    end

    assign waterDeath = waterHit && !hop_active && (cntInc >= 3'(WATER_CONFIRM));
    assign edgeDeath  = drift_en && (( drift_left && (frogX <= XMin)) ||
                                     (!drift_left && (frogX >= XMax)));
    assign dieNow     = waterDeath || edgeDeath;
    assign animStart  = (state == ALIVE) && dieNow;

    frog_death_anim #(
        .DIE_FRAMES (DIE_FRAMES)
    ) u_anim (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .start       (animStart),
        .death_cnt   (unusedDeathCnt),
        .death_frame (death_frame),
        .done        (animDone)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= ALIVE;
            lives      <= 2'(LIVES_INIT);
            waterCnt   <= '0;
            drift_en   <= 1'b0;
            drift_left <= 1'b0;
            drift_step <= '0;
            dying      <= 1'b0;
            respawn    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            case (state)
                ALIVE: begin
                    if (dieNow) begin
                        state      <= DYING;
                        dying      <= 1'b1;
                        waterCnt   <= '0;
                        drift_en   <= 1'b0;
                        drift_left <= 1'b0;
                        drift_step <= '0;
                    end else begin
                        waterCnt   <= cntInc;
                        drift_en   <= enNext;
                        drift_left <= leftNext;
                        drift_step <= stepNext;
                    end
                end
                DYING: begin
                    if (animDone) begin
                        dying <= 1'b0;
                        if (lives == 2'd1) begin
                            state     <= OVER;
                            lives     <= '0;
                            game_over <= 1'b1;
                        end else begin
                            state   <= RESPAWN;
                            lives   <= lives - 2'd1;
                            respawn <= 1'b1;
                        end
                    end
                end
                RESPAWN: begin
                    state   <= ALIVE;
                    respawn <= 1'b0;
                end
                OVER: begin
                    game_over <= 1'b1;
                end
                default: state <= ALIVE;
            endcase
        end
    end

endmodule
